// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake and instruction-memory write port.
//   in_data/in_valid/in_ready : byte stream, transferred when valid && ready
//   imem_we/imem_addr/imem_wdata : one-cycle word write into instruction memory
// Modports: master = loader side (consumes stream, drives memory writes),
//           slave  = stream source / memory side.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 6
);
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;

    modport master (
        input  in_data, in_valid,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the instruction memory.
// Takes a count byte N, then 4*N bytes assembled big-endian into 32-bit
// words, written sequentially from word address 0. The processor is held in
// reset until the image is complete.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : stream input + memory write port (master modport)
//   restart    : single-cycle pulse, starts a new load from DONE
//   cpu_reset  : processor reset hold, high while loading (and after error)
//   done       : load finished (valid or error)
//   err        : count exceeded memory capacity
module imem_loader #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.master bus,
    input  logic          restart,
    output logic          cpu_reset,
    output logic          done,
    output logic          err
);
    typedef enum logic [1:0] {S_COUNT, S_DATA, S_WRITE, S_DONE} state_t;

    localparam logic [8:0] CAPACITY = 9'(1 << ADDR_WIDTH);

    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH:0]   widx_q, widx_d;   // one extra bit so N = capacity fits
    logic [1:0]            bidx_q, bidx_d;
    logic [23:0]           buf_q, buf_d;     // first three bytes of the word
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic rdy;
    logic accept;
    logic last_word;

    assign accept    = bus.in_valid && rdy;
    assign last_word = (9'(widx_q) + 9'd1) == {1'b0, cnt_q};

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_COUNT;
            cnt_q       <= '0;
            widx_q      <= '0;
            bidx_q      <= '0;
            buf_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            widx_q      <= widx_d;
            bidx_q      <= bidx_d;
            buf_q       <= buf_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic. Memory-port and status outputs are computed here so
    // they are registered on the same edge that enters WRITE / DONE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        widx_d      = widx_q;
        bidx_d      = bidx_q;
        buf_d       = buf_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_reset_d = cpu_reset_q;
        done_d      = done_q;
        err_d       = err_q;
        case (state_q)
            S_COUNT: begin
                if (accept) begin
                    cnt_d  = bus.in_data;
                    widx_d = '0;
                    bidx_d = '0;
                    if (bus.in_data == 8'd0) begin
                        state_d     = S_DONE;
                        done_d      = 1'b1;
                        cpu_reset_d = 1'b0;
                    end else if ({1'b0, bus.in_data} > CAPACITY) begin
                        // Image too large: report error, keep CPU in reset.
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    if (bidx_q == 2'd3) begin
                        state_d = S_WRITE;
                        we_d    = 1'b1;
                        addr_d  = widx_q[ADDR_WIDTH-1:0];
                        wdata_d = {buf_q, bus.in_data};
                        bidx_d  = '0;
                    end else begin
                        buf_d  = {buf_q[15:0], bus.in_data};
                        bidx_d = bidx_q + 2'd1;
                    end
                end
            end
            S_WRITE: begin
                widx_d = widx_q + 1'b1;
                if (last_word) begin
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    cpu_reset_d = 1'b0;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_DONE: begin
                if (restart) begin
                    state_d     = S_COUNT;
                    cpu_reset_d = 1'b1;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    widx_d      = '0;
                    bidx_d      = '0;
                end
            end
            default: state_d = S_COUNT;
        endcase
    end

    // Output logic
    always_comb begin
        rdy            = (state_q == S_COUNT) || (state_q == S_DATA);
        bus.in_ready   = rdy;
        bus.imem_we    = we_q;
        bus.imem_addr  = addr_q;
        bus.imem_wdata = wdata_q;
        cpu_reset      = cpu_reset_q;
        done           = done_q;
        err            = err_q;
    end
endmodule
